seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle signed 32-bit integer divider, the inverse counterpart of the Booth multiplier in the datapath's multiply/divide unit. Takes a dividend and divisor, iterates one quotient bit per clock (restoring shift-subtract on magnitudes), then sign-corrects. Writes the quotient into the LO half and the remainder into the HI half of the shared HI/LO register pair, so a DIV instruction fills HI/LO the same way MUL does.

## Interface
Parameters:
- WIDTH, 32, operand and result width; fixed at 32 for the datapath.
- ITER, WIDTH, number of CALC cycles; always equals WIDTH.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- clr  in  1  reset; synchronous, active-high.
- start  in  1  request a division; sampled only in IDLE.
- a  in  32  signed dividend; captured on the accepting edge.
- b  in  32  signed divisor; captured on the accepting edge.
- busy  out  1  high from the accepting edge until the edge that raises done.
- done  out  1  one-cycle pulse; cHI/cLOW valid and stable from this cycle on.
- div_zero  out  1  set with done when b was 0; held until the next done.
- cHI  out  32  remainder; sign follows the dividend.
- cLOW  out  32  quotient, truncated toward zero.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: when start=1, latch a and b. Latch sign_q = a[31]^b[31] and sign_r = a[31]. Load the magnitude |a| into the quotient shift register, clear the 33-bit partial remainder, set the counter to 0, and go to CALC. When start=0, stay in IDLE.
- CALC, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem − |b|, 33-bit.
  - If trial ≥ 0: rem = trial and quo[0] = 1. Otherwise restore rem and set quo[0] = 0.
  - The counter increments each cycle. After iteration 31 (counter = 31), go to FIX.
- FIX: negate quo if sign_q, negate rem if sign_r (two's complement, mod 2^32). Register the results into cHI/cLOW and go to DONE.
- DONE: done = 1 for exactly one cycle, busy = 0, then return to IDLE unconditionally.
- Special cases (always resolved in FIX; latency is unchanged):
  - b = 0: cLOW = 0xFFFF_FFFF, cHI = a, div_zero = 1.
  - a = 0x8000_0000 with b = 0xFFFF_FFFF: cLOW = 0x8000_0000, cHI = 0, div_zero = 0.
  - |a| of 0x8000_0000 is 0x8000_0000 as unsigned. The magnitude path is 32-bit unsigned plus a 33rd bit for trial.
- start while busy is ignored; it does not queue. start in the DONE cycle is also ignored. start is accepted again from IDLE.
- a and b may change after the accepting edge with no effect.
- cHI, cLOW and div_zero hold their values between done pulses and change only on the FIX→DONE edge.

## Timing
- Reset values: busy = 0, done = 0, div_zero = 0, cHI = 0, cLOW = 0, state = IDLE, counter = 0.
- clr has priority over every other input, including mid-CALC. The operation is discarded, no done is produced, and the next start is accepted in the first cycle after clr deasserts.
- Latency is fixed:
  - Edge E0 accepts start.
  - CALC occupies edges E1..E32.
  - FIX occupies edge E33.
  - Edge E34 enters DONE, so done is high in the cycle after E34. Results are registered on E34.
- busy is high from after E0 through the cycle after E33, and low in the DONE cycle.
- Minimum issue interval is 36 cycles: start may be sampled high at E36, the first edge back in IDLE.

## Test plan
- Basic signed division: a=100, b=7. Expect done 34 edges after acceptance, cLOW=14, cHI=2, div_zero=0.
- Sign rules:
  - a=−100, b=7 → cLOW=0xFFFF_FFF2 (−14), cHI=0xFFFF_FFFE (−2).
  - a=100, b=−7 → cLOW=−14, cHI=2.
  - a=−100, b=−7 → cLOW=14, cHI=−2.
- Boundaries:
  - a=0x8000_0000, b=0xFFFF_FFFF → cLOW=0x8000_0000, cHI=0.
  - a=0x8000_0000, b=1 → cLOW=0x8000_0000, cHI=0.
  - a=0x7FFF_FFFF, b=0x7FFF_FFFF → cLOW=1, cHI=0.
- Divide by zero: a=0x1234_5678, b=0 → cLOW=0xFFFF_FFFF, cHI=0x1234_5678, div_zero=1, same 34-edge latency. A following 9/3 → cLOW=3, cHI=0, div_zero=0.
- Handshake: hold start high continuously with changing a and b.
  - Only the operands present at the accepting edges are used.
  - done pulses once per 36 cycles.
  - outputs hold steady between pulses.
- Reset mid-operation: assert clr at CALC iteration 10.
  - Next cycle: busy=0, cHI=cLOW=0, no done pulse.
  - A new 50/5 started afterward completes with cLOW=10, cHI=0.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider writing quotient to cLOW and remainder to cHI
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] cHI,
  output logic [WIDTH-1:0] cLOW
);
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_ph;
  logic [WIDTH-1:0] r_quo, r_rem, r_a, r_bmag, r_hi, r_lo;
  logic             r_sign_q, r_sign_r, r_bzero, r_dz;
  logic [WIDTH-1:0] w_amag, w_bmag;
  logic [WIDTH:0]   w_sh, w_trial;
  logic             w_ge;
  assign w_amag  = a[WIDTH-1] ? -a : a;
  assign w_bmag  = b[WIDTH-1] ? -b : b;
  assign w_sh    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_sh - {1'b0, r_bmag};
  assign w_ge    = ~w_trial[WIDTH];
  // state register
  always_ff @(posedge clk)
    r_state <= clr ? S_IDLE : w_next;
  // next state: FIX lasts two cycles (correct, then publish)
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_CALC : S_IDLE;
      S_CALC:  w_next = (r_cnt == LAST) ? S_FIX : S_CALC;
      S_FIX:   w_next = r_ph ? S_DONE : S_FIX;
      default: w_next = S_IDLE;
    endcase
  end
  // outputs decoded from state and result registers
  always_comb begin
    busy     = (r_state == S_CALC) || (r_state == S_FIX);
    done     = r_state == S_DONE;
    div_zero = r_dz;
    cHI      = r_hi;
    cLOW     = r_lo;
  end
  // datapath: operand capture, shift-subtract iterations, sign fix, result publish
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt    <= '0;
      r_ph     <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_a      <= '0;
      r_bmag   <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_bzero  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_a      <= a;
          r_bmag   <= w_bmag;
          r_bzero  <= b == '0;
          r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
          r_sign_r <= a[WIDTH-1];
          r_quo    <= w_amag;
          r_rem    <= '0;
          r_cnt    <= '0;
          r_ph     <= 1'b0;
        end
        S_CALC: begin
          r_rem <= w_ge ? w_trial[WIDTH-1:0] : w_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: if (!r_ph) begin
          r_quo <= r_sign_q ? -r_quo : r_quo;
          r_rem <= r_sign_r ? -r_rem : r_rem;
          r_ph  <= 1'b1;
        end else begin
          r_lo <= r_bzero ? '1 : r_quo;
          r_hi <= r_bzero ? r_a : r_rem;
          r_dz <= r_bzero;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: random and directed checks of seq_divider against an arithmetic reference
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        clr, start, busy, done, div_zero;
  logic [31:0] a, b, cHI, cLOW;
  int          n_chk = 0, n_fail = 0;
  seq_divider dut (
    .clk(clk), .clr(clr), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .cHI(cHI), .cLOW(cLOW)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    z = y == 32'd0;
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end
  endfunction
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] q, r;
    logic        z;
    int          k;
    model(x, y, q, r, z);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    check({tag, ".busy"}, busy, 1);
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, ".lat"}, k, 34);
    check({tag, ".busy_done"}, busy, 0);
    check({tag, ".lo"}, cLOW, q);
    check({tag, ".hi"}, cHI, r);
    check({tag, ".dz"}, div_zero, z);
    @(posedge clk); #1;
    check({tag, ".pulse"}, done, 0);
    check({tag, ".hold"}, cLOW, q);
  endtask
  logic [31:0] da [9] = '{32'd100, -32'd100, 32'd100, -32'd100, 32'h8000_0000, 32'h8000_0000,
                          32'h7FFF_FFFF, 32'h1234_5678, 32'd9};
  logic [31:0] db [9] = '{32'd7, 32'd7, -32'd7, -32'd7, 32'hFFFF_FFFF, 32'd1,
                          32'h7FFF_FFFF, 32'd0, 32'd3};
  initial begin
    logic [31:0] eq [3], er [3];
    logic        ez [3];
    logic [31:0] x, y, last_lo, last_hi;
    int          n_done, seen;
    clr = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.dz", div_zero, 0);
    check("rst.hi", cHI, 0);
    check("rst.lo", cLOW, 0);
    clr = 1'b0;
    for (int i = 0; i < 9; i++) run_op(da[i], db[i], $sformatf("dir%0d", i));
    for (int i = 0; i < 16; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 4 == 1) y = 32'($urandom_range(1, 50));
      if (i % 4 == 2) y = -32'($urandom_range(1, 50));
      if (i % 4 == 3) x = 32'($urandom_range(0, 1000));
      run_op(x, y, $sformatf("rnd%0d", i));
    end
    n_done = 0;
    last_lo = cLOW;
    last_hi = cHI;
    start = 1'b1;
    for (int c = 0; c < 108; c++) begin
      a = $urandom;
      b = (c % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      if (c % 36 == 0) model(a, b, eq[c / 36], er[c / 36], ez[c / 36]);
      @(posedge clk); #1;
      if (done) begin
        check("hs.phase", c % 36, 34);
        if (n_done < 3) begin
          check("hs.lo", cLOW, eq[n_done]);
          check("hs.hi", cHI, er[n_done]);
          check("hs.dz", div_zero, ez[n_done]);
        end
        n_done++;
        last_lo = cLOW;
        last_hi = cHI;
      end else begin
        check("hs.hold_lo", cLOW, last_lo);
        check("hs.hold_hi", cHI, last_hi);
      end
    end
    start = 1'b0;
    check("hs.count", n_done, 3);
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    check("clr.busy", busy, 0);
    check("clr.done", done, 0);
    check("clr.hi", cHI, 0);
    check("clr.lo", cLOW, 0);
    clr = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("clr.no_done", seen, 0);
    run_op(32'd50, 32'd5, "post_clr");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
